// File: rtl/sysbus_mem_responder.sv
// Sysbus line-protocol responder: 8-beat line reads/writes into a 64-bit word array.
// Optional MMIO hole (640 KB < line addr < 1 MB) enabled by defining SYSBUS_MEM_MMIO_EN.
module sysbus_mem_responder #(
  parameter int MEM_WORDS    = 65536,
  parameter int READ_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_cyc,
  input  logic [63:0] req,
  input  logic [15:0] req_tag,
  output logic        req_ack,
  output logic        resp_cyc,
  output logic [63:0] resp,
  output logic [15:0] resp_tag,
  input  logic        resp_ack,
  output logic        busy
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int LINE_W = IDX_W - 3;
  localparam logic [7:0] LAT_LOAD = 8'(READ_LATENCY - 1);

  // state | meaning: IDLE wait for address | WR_DATA take write beats | RD_WAIT latency | RD_BURST return beats
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WR_DATA  = 2'd1;
  localparam logic [1:0] S_RD_WAIT  = 2'd2;
  localparam logic [1:0] S_RD_BURST = 2'd3;

  logic [1:0]        r_state;
  logic [LINE_W-1:0] r_line;
  logic [15:0]       r_tag;
  logic [2:0]        r_beat;
  logic [7:0]        r_lat;
  logic              r_busy;
  logic              r_mmio;
  logic [63:0]       r_mem [MEM_WORDS];

  logic              w_mmio;
  logic [IDX_W-1:0]  w_idx;
  logic              w_wr_en;

`ifdef SYSBUS_MEM_MMIO_EN
  logic [63:0] w_line_addr;
  assign w_line_addr = {req[63:6], 6'b0};
  assign w_mmio      = (w_line_addr > 64'h000A_0000) && (w_line_addr < 64'h0010_0000);
`else
  assign w_mmio = 1'b0;
`endif

  assign req_ack = !reset && req_cyc && (r_state == S_IDLE || r_state == S_WR_DATA);
  // Line index concatenated with beat gives (line*8 + beat) mod MEM_WORDS.
  assign w_idx   = {r_line, r_beat};
  assign w_wr_en = req_ack && (r_state == S_WR_DATA) && !r_mmio;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_line  <= '0;
      r_tag   <= '0;
      r_beat  <= '0;
      r_lat   <= '0;
      r_busy  <= 1'b0;
      r_mmio  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_cyc) begin
            r_line <= req[6 +: LINE_W];
            r_tag  <= req_tag;
            r_mmio <= w_mmio;
            r_beat <= '0;
            r_busy <= 1'b1;
            if (req_tag[12]) begin
              r_state <= S_RD_WAIT;
              r_lat   <= LAT_LOAD;
            end else begin
              r_state <= S_WR_DATA;
            end
          end
        end
        S_WR_DATA: begin
          if (req_cyc) begin
            r_beat <= r_beat + 3'd1;
            if (r_beat == 3'd7) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_RD_WAIT: begin
          if (r_lat == 8'd0) begin
            r_state <= S_RD_BURST;
            r_beat  <= '0;
          end else begin
            r_lat <= r_lat - 8'd1;
          end
        end
        S_RD_BURST: begin
          if (resp_ack) begin
            r_beat <= r_beat + 3'd1;
            if (r_beat == 3'd7) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Array is never reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_idx] <= req;
  end

  assign resp_cyc = (r_state == S_RD_BURST);
  assign resp     = (resp_cyc && !r_mmio) ? r_mem[w_idx] : 64'h0;
  assign resp_tag = resp_cyc ? r_tag : 16'h0;
  assign busy     = r_busy;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder: word-indexed reference memory, queued expected beats.
module tb_sysbus_mem_responder;
  localparam int MEM_WORDS    = 65536;
  localparam int READ_LATENCY = 4;
  localparam int BOUND        = 600;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_cyc = 1'b0;
  logic [63:0] req = '0;
  logic [15:0] req_tag = '0;
  logic        resp_ack = 1'b0;
  logic        req_ack;
  logic        resp_cyc;
  logic [63:0] resp;
  logic [15:0] resp_tag;
  logic        busy;

  sysbus_mem_responder #(.MEM_WORDS(MEM_WORDS), .READ_LATENCY(READ_LATENCY)) dut (
    .clk(clk), .reset(reset), .req_cyc(req_cyc), .req(req), .req_tag(req_tag),
    .req_ack(req_ack), .resp_cyc(resp_cyc), .resp(resp), .resp_tag(resp_tag),
    .resp_ack(resp_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [63:0] data;
    logic [15:0] tag;
  } beat_t;

  int          n_checks = 0;
  int          n_fail = 0;
  beat_t       exp_q[$];
  int          lat_q[$];
  logic [63:0] mem_m [longint];
  logic [63:0] written_lines[$];
  bit          rd_out = 0;
  bit          lat_done = 0;
  int          mon_beat = 0;
  int          ack_mode = 0;
  int          stall_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no response within %0d cycles expected one (t=%0t)", name, BOUND, $time);
  endtask

  function automatic longint widx(input logic [63:0] addr, input int b);
    return longint'((((addr >> 6) * 64'd8) + 64'(b)) % 64'(MEM_WORDS));
  endfunction

  function automatic bit is_mmio(input logic [63:0] addr);
`ifdef SYSBUS_MEM_MMIO_EN
    logic [63:0] la;
    la = {addr[63:6], 6'b0};
    return (la > 64'hA0000) && (la < 64'h100000);
`else
    return addr[0] && 1'b0;
`endif
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive(input logic [63:0] d, input logic [15:0] t, output int ack_cyc);
    int n;
    n = 0;
    ack_cyc = -1;
    req_cyc = 1'b1;
    req = d;
    req_tag = t;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ack && n < BOUND);
    if (!req_ack) bound_fail("req_ack_timeout");
    else ack_cyc = cyc;
    @(posedge clk);
    #1;
    req_cyc = 1'b0;
  endtask

  task automatic write_line(input logic [63:0] addr, input logic [63:0] d[8],
                            input int gap_after, input int gap_len);
    int ac;
    logic [15:0] t;
    t = (16'($urandom) & 16'hE0FF) | 16'h0100;
    drive(addr, t, ac);
    for (int b = 0; b < 8; b++) begin
      drive(d[b], t, ac);
      if (!is_mmio(addr)) mem_m[widx(addr, b)] = d[b];
      if (b == gap_after) begin
        repeat (gap_len) begin
          @(negedge clk);
          check("gap_no_ack", 64'(req_ack), 64'd0);
          check("gap_busy", 64'(busy), 64'd1);
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic read_line(input logic [63:0] addr, input logic [15:0] t);
    int ac;
    beat_t e;
    for (int b = 0; b < 8; b++) begin
      e.tag = t;
      if (is_mmio(addr)) e.data = 64'h0;
      else if (mem_m.exists(widx(addr, b))) e.data = mem_m[widx(addr, b)];
      else e.data = 64'h0;
      exp_q.push_back(e);
    end
    drive(addr, t, ac);
    if (ac >= 0) lat_q.push_back(ac + 1 + READ_LATENCY);
    rd_out = 1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((rd_out || exp_q.size() > 0) && n < BOUND) begin
      @(posedge clk);
      n++;
    end
    if (rd_out || exp_q.size() > 0) begin
      bound_fail("burst_timeout");
      exp_q.delete();
      lat_q.delete();
      rd_out = 0;
      mon_beat = 0;
      lat_done = 0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rd_tag();
    return (16'($urandom) & 16'hE0FF) | 16'h1100;
  endfunction

  always @(posedge clk) begin
    #1;
    case (ack_mode)
      0: resp_ack = ($urandom_range(0, 3) != 0);
      2: begin
        if (resp_cyc && mon_beat == 2 && stall_n < 3) begin
          resp_ack = 1'b0;
          stall_n++;
        end else begin
          resp_ack = 1'b1;
        end
      end
      3: resp_ack = (mon_beat < 3);
      default: resp_ack = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (rd_out && req_cyc) check("ack_blocked_in_read", 64'(req_ack), 64'd0);
      if (ack_mode == 2 && mon_beat == 2 && stall_n > 0 && exp_q.size() > 0)
        check("stall_resp_cyc", 64'(resp_cyc), 64'd1);
      if (resp_cyc) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got resp_cyc=1 resp=%h expected no beat (t=%0t)", resp, $time);
        end else begin
          if (!lat_done) begin
            lat_done = 1;
            if (lat_q.size() > 0) check("read_latency", 64'(cyc), 64'(lat_q.pop_front()));
          end
          check("resp_data", resp, exp_q[0].data);
          check("resp_tag", 64'(resp_tag), 64'(exp_q[0].tag));
          if (resp_ack) begin
            void'(exp_q.pop_front());
            mon_beat++;
            if (mon_beat == 8) begin
              mon_beat = 0;
              lat_done = 0;
              rd_out = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] d[8];
    logic [63:0] a;
    logic [63:0] base;
    int n;
    int k;

    // reset state, req_ack forced low while reset is high
    req_cyc = 1'b1;
    req_tag = 16'h1100;
    #1;
    check("rst_req_ack", 64'(req_ack), 64'd0);
    check("rst_resp_cyc", 64'(resp_cyc), 64'd0);
    check("rst_resp", resp, 64'd0);
    check("rst_resp_tag", 64'(resp_tag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    req_cyc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // line write then read with exact latency
    for (int b = 0; b < 8; b++) d[b] = 64'(b + 1) * 64'h11;
    write_line(64'h1000, d, -1, 0);
    written_lines.push_back(64'h1000);
    check("idle_after_write", 64'(busy), 64'd0);
    ack_mode = 1;
    read_line(64'h1000, 16'h1100);
    wait_done();

    // three-cycle stall on beat 2
    ack_mode = 2;
    stall_n = 0;
    read_line(64'h1000, 16'h1155);
    wait_done();
    check("stall_cycles", 64'(stall_n), 64'd3);

    // write with a 2-cycle bubble between beats 3 and 4
    ack_mode = 0;
    for (int b = 0; b < 8; b++) d[b] = {$urandom, $urandom};
    write_line(64'h2000, d, 3, 2);
    written_lines.push_back(64'h2000);
    read_line(64'h2000, rd_tag());
    wait_done();

    // wrapped alias with ignored low bits, second read queued behind it
    read_line(64'h1000 + 64'(MEM_WORDS) * 64'd8 + 64'h28, 16'h1A01);
    read_line(64'h2000, 16'h1302);
    wait_done();

    // reset in the middle of a burst at beat 3
    ack_mode = 3;
    read_line(64'h1000, 16'h1777);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(resp_cyc && !resp_ack && mon_beat == 3) && n < BOUND);
    if (n >= BOUND) bound_fail("reach_beat3");
    #3;
    reset = 1'b1;
    req_cyc = 1'b1;
    req_tag = 16'h1100;
    #1;
    check("midrst_resp_cyc", 64'(resp_cyc), 64'd0);
    check("midrst_resp", resp, 64'd0);
    check("midrst_resp_tag", 64'(resp_tag), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_req_ack", 64'(req_ack), 64'd0);
    exp_q.delete();
    lat_q.delete();
    rd_out = 0;
    mon_beat = 0;
    lat_done = 0;
    repeat (2) @(posedge clk);
    #1;
    req_cyc = 1'b0;
    reset = 1'b0;
    ack_mode = 0;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_busy", 64'(busy), 64'd0);
    read_line(64'h1000, rd_tag());
    wait_done();

    // MMIO window line (zeros when the window is compiled in, data otherwise)
    for (int b = 0; b < 8; b++) d[b] = {$urandom, $urandom};
    d[0] = 64'hDEAD;
    write_line(64'hA0040, d, -1, 0);
    read_line(64'hA0040, 16'h1BEE);
    wait_done();

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 3);
      if (k == 3) k = 7;
      if ($urandom_range(0, 2) == 0 || written_lines.size() < 3) begin
        base = 64'($urandom_range(0, 2047)) << 6;
        for (int b = 0; b < 8; b++) d[b] = {$urandom, $urandom};
        a = base + 64'(k) * 64'(MEM_WORDS) * 64'd8 + 64'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) write_line(a, d, $urandom_range(0, 7), $urandom_range(1, 3));
        else write_line(a, d, -1, 0);
        written_lines.push_back(base);
      end else begin
        base = written_lines[$urandom_range(0, written_lines.size() - 1)];
        a = base + 64'(k) * 64'(MEM_WORDS) * 64'd8 + 64'($urandom_range(0, 63));
        read_line(a, rd_tag());
        if ($urandom_range(0, 1) == 1) wait_done();
      end
    end
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
